// File: rtl/output_serializer_pkg.sv
// -----------------------------------------------------------------------------
// output_serializer_pkg
// Shared definitions for the result serializer and its bus interface.
//   RESULT_WIDTH : width of the calculator result bus and of one serial frame
//   COUNT_WIDTH  : width of the frame bit counter
//   serState_e   : serializer FSM state encoding
//   countWidth() : counter width needed to index a frame of a given length
// -----------------------------------------------------------------------------
package output_serializer_pkg;

   localparam int RESULT_WIDTH = 40;

   function automatic int countWidth(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   localparam int COUNT_WIDTH = countWidth(RESULT_WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } serState_e;

endpackage

// File: rtl/output_serializer_if.sv
// -----------------------------------------------------------------------------
// output_serializer_if
// Bus between the per-sample calculator and the result serializer.
//   overallResult  : result word, valid while thisNCompleted is high
//   thisNCompleted : completion level; a rising edge marks a new result
//   outBit         : serial data, MSB first
//   outReady       : high on every cycle outBit carries a frame bit
//   busy           : serializer shifting or holding a pending word
//   overflow       : sticky, a result was dropped
// Modports: master = calculator side, slave = serializer side.
// -----------------------------------------------------------------------------
interface output_serializer_if #(
   parameter int RESULT_WIDTH = output_serializer_pkg::RESULT_WIDTH
);

   logic [RESULT_WIDTH-1:0] overallResult;
   logic                    thisNCompleted;
   logic                    outBit;
   logic                    outReady;
   logic                    busy;
   logic                    overflow;

   modport master (
      output overallResult,
      output thisNCompleted,
      input  outBit,
      input  outReady,
      input  busy,
      input  overflow
   );

   modport slave (
      input  overallResult,
      input  thisNCompleted,
      output outBit,
      output outReady,
      output busy,
      output overflow
   );

endinterface

// File: rtl/output_serializer.sv
// -----------------------------------------------------------------------------
// output_serializer
// Captures each calculator result on the rising edge of thisNCompleted and
// shifts it out MSB first, one bit per sClk cycle, with outReady marking frame
// bits. One pending word absorbs a result arriving mid-frame; any further
// result in the same frame is dropped and flagged on the sticky overflow.
//   sClk    : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of output_serializer_if
// -----------------------------------------------------------------------------
module output_serializer #(
   parameter int RESULT_WIDTH = output_serializer_pkg::RESULT_WIDTH
) (
   input  logic                sClk,
   input  logic                reset_n,
   output_serializer_if.slave  bus
);

   import output_serializer_pkg::*;

   localparam int                CountW    = countWidth(RESULT_WIDTH);
   localparam logic [CountW-1:0] LastCount = CountW'(RESULT_WIDTH - 1);

   serState_e               state,          stateNext;
   logic [RESULT_WIDTH-1:0] shiftReg,       shiftNext;
   logic [RESULT_WIDTH-1:0] pendingReg,     pendingRegNext;
   logic                    pendingValid,   pendingValidNext;
   logic [CountW-1:0]       bitCount,       bitCountNext;
   logic                    outBitReg,      outBitNext;
   logic                    outReadyReg,    outReadyNext;
   logic                    overflowReg,    overflowNext;
   logic                    doneD;

   logic                    newResult;
   logic                    doLoad;
   logic [RESULT_WIDTH-1:0] loadWord;

   assign newResult = bus.thisNCompleted & ~doneD;

   always_comb begin
      stateNext        = state;
      shiftNext        = shiftReg;
      pendingRegNext   = pendingReg;
      pendingValidNext = pendingValid;
      bitCountNext     = bitCount;
      outBitNext       = outBitReg;
      outReadyNext     = outReadyReg;
      overflowNext     = overflowReg;
      doLoad           = 1'b0;
      loadWord         = bus.overallResult;

      unique case (state)
         IDLE: begin
            if (newResult) begin
               doLoad = 1'b1;
            end
         end
         SHIFT: begin
            if (bitCount == LastCount) begin
               // Last bit is on the outputs: chain the next word with no gap,
               // the pending word taking priority over a fresh arrival.
               if (pendingValid) begin
                  doLoad   = 1'b1;
                  loadWord = pendingReg;
                  if (newResult) begin
                     pendingRegNext = bus.overallResult;
                  end else begin
                     pendingValidNext = 1'b0;
                  end
               end else if (newResult) begin
                  doLoad = 1'b1;
               end else begin
                  stateNext    = IDLE;
                  outReadyNext = 1'b0;
                  outBitNext   = 1'b0;
                  bitCountNext = '0;
               end
            end else begin
               outBitNext   = shiftReg[RESULT_WIDTH-1];
               shiftNext    = {shiftReg[RESULT_WIDTH-2:0], 1'b0};
               bitCountNext = bitCount + CountW'(1);
               if (newResult) begin
                  if (!pendingValid) begin
                     pendingRegNext   = bus.overallResult;
                     pendingValidNext = 1'b1;
                  end else begin
                     overflowNext = 1'b1;
                  end
               end
            end
         end
      endcase

      // A load puts the MSB straight on the output and keeps the rest queued.
      if (doLoad) begin
         outBitNext   = loadWord[RESULT_WIDTH-1];
         shiftNext    = {loadWord[RESULT_WIDTH-2:0], 1'b0};
         outReadyNext = 1'b1;
         bitCountNext = '0;
         stateNext    = SHIFT;
      end
   end

   always_ff @(posedge sClk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         shiftReg     <= '0;
         pendingReg   <= '0;
         pendingValid <= 1'b0;
         bitCount     <= '0;
         outBitReg    <= 1'b0;
         outReadyReg  <= 1'b0;
         overflowReg  <= 1'b0;
         doneD        <= 1'b0;
      end else begin
         state        <= stateNext;
         shiftReg     <= shiftNext;
         pendingReg   <= pendingRegNext;
         pendingValid <= pendingValidNext;
         bitCount     <= bitCountNext;
         outBitReg    <= outBitNext;
         outReadyReg  <= outReadyNext;
         overflowReg  <= overflowNext;
         doneD        <= bus.thisNCompleted;
      end
   end

   assign bus.outBit   = outBitReg;
   assign bus.outReady = outReadyReg;
   assign bus.overflow = overflowReg;
   assign bus.busy     = (state == SHIFT) | pendingValid;

endmodule

// File: tb/tb_output_serializer.sv
// -----------------------------------------------------------------------------
// tb_output_serializer
// Directed stimulus for output_serializer. Each issued result that should
// appear on the serial output is pushed bit by bit (MSB first) into an
// expected-bit queue; a negedge monitor pops and compares every outReady bit.
// -----------------------------------------------------------------------------
module tb_output_serializer;

   import output_serializer_pkg::*;

   localparam int RW = RESULT_WIDTH;

   logic sClk;
   logic reset_n;
   logic monOn;
   int   total;
   int   bad;
   logic expQ[$];

   output_serializer_if #(.RESULT_WIDTH(RW)) bus ();

   output_serializer #(.RESULT_WIDTH(RW)) dut (
      .sClk    (sClk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial sClk = 1'b0;
   always #5 sClk = ~sClk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pushWord(input logic [RW-1:0] w);
      for (int i = RW - 1; i >= 0; i--) expQ.push_back(w[i]);
   endtask

   // Called just after a rising edge: raise completion for one cycle.
   task automatic pulse(input logic [RW-1:0] w, input bit expectOut);
      bus.overallResult  = w;
      bus.thisNCompleted = 1'b1;
      if (expectOut) pushWord(w);
      @(posedge sClk);
      #1;
      bus.thisNCompleted = 1'b0;
   endtask

   task automatic rise(input logic [RW-1:0] w);
      @(posedge sClk);
      #1;
      pulse(w, 1'b1);
   endtask

   // Counts consecutive outReady cycles, waiting a bounded time for the start.
   task automatic measureRun(output int len);
      int waitN;
      waitN = 0;
      len   = 0;
      @(negedge sClk);
      while (!bus.outReady && waitN < 10) begin
         @(negedge sClk);
         waitN++;
      end
      while (bus.outReady && len < 400) begin
         len++;
         @(negedge sClk);
      end
   endtask

   // Scoreboard monitor
   always @(negedge sClk) begin
      if (monOn) begin
         if (bus.outReady) begin
            if (expQ.size() == 0) check("unexpectedBit", 64'd1, 64'd0);
            else check("outBit", {63'd0, bus.outBit}, {63'd0, expQ.pop_front()});
         end else begin
            check("idleOutBit", {63'd0, bus.outBit}, 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      total              = 0;
      bad                = 0;
      monOn              = 1'b0;
      bus.overallResult  = '0;
      bus.thisNCompleted = 1'b0;
      reset_n            = 1'b1;
      #1 reset_n = 1'b0;
      #20;
      check("rstOutBit",   {63'd0, bus.outBit},   64'd0);
      check("rstOutReady", {63'd0, bus.outReady}, 64'd0);
      check("rstBusy",     {63'd0, bus.busy},     64'd0);
      check("rstOverflow", {63'd0, bus.overflow}, 64'd0);
      @(negedge sClk);
      reset_n = 1'b1;
      monOn   = 1'b1;

      // Single frame: 1, 38 zeros, 1
      rise(40'h80_0000_0001);
      measureRun(len);
      check("t1Len", 64'(len), 64'd40);
      check("t1Busy", {63'd0, bus.busy}, 64'd0);
      check("t1Empty", 64'(expQ.size()), 64'd0);

      // Level held high: exactly one frame
      @(posedge sClk);
      #1;
      bus.overallResult  = 40'hFF_FFFF_FFFF;
      bus.thisNCompleted = 1'b1;
      pushWord(40'hFF_FFFF_FFFF);
      measureRun(len);
      check("t2Len", 64'(len), 64'd40);
      repeat (158) @(posedge sClk);
      #1;
      check("t2OutReady", {63'd0, bus.outReady}, 64'd0);
      check("t2Busy",     {63'd0, bus.busy},     64'd0);
      check("t2Overflow", {63'd0, bus.overflow}, 64'd0);
      bus.thisNCompleted = 1'b0;
      check("t2Empty", 64'(expQ.size()), 64'd0);

      // Second rise around frame bit 10: gapless 80-bit run
      rise(40'h12_3456_789A);
      fork
         measureRun(len);
         begin
            repeat (8) @(posedge sClk);
            #1;
            pulse(40'hAA_AAAA_AAAA, 1'b1);
         end
      join
      check("t3Len", 64'(len), 64'd80);
      check("t3Busy", {63'd0, bus.busy}, 64'd0);
      check("t3Overflow", {63'd0, bus.overflow}, 64'd0);
      check("t3Empty", 64'(expQ.size()), 64'd0);

      // Rise on the last-bit cycle while a word is pending
      rise(40'hC3_0F0F_1234);
      fork
         measureRun(len);
         begin
            repeat (3) @(posedge sClk);
            #1;
            pulse(40'h5A_A55A_0FF0, 1'b1);
            repeat (35) @(posedge sClk);
            #1;
            pulse(40'h01_2345_6789, 1'b1);
         end
      join
      check("t5Len", 64'(len), 64'd120);
      check("t5Overflow", {63'd0, bus.overflow}, 64'd0);
      check("t5Empty", 64'(expQ.size()), 64'd0);

      // Three rises in one frame: third dropped, overflow sticks
      rise(40'hF0_1234_5678);
      fork
         measureRun(len);
         begin
            repeat (4) @(posedge sClk);
            #1;
            pulse(40'h0F_EDCB_A987, 1'b1);
            check("t4OvfBefore", {63'd0, bus.overflow}, 64'd0);
            repeat (4) @(posedge sClk);
            #1;
            pulse(40'h3C_3C3C_3C3C, 1'b0);
            check("t4OvfSet", {63'd0, bus.overflow}, 64'd1);
         end
      join
      check("t4Len", 64'(len), 64'd80);
      repeat (5) @(posedge sClk);
      #1;
      check("t4OvfSticky", {63'd0, bus.overflow}, 64'd1);
      check("t4Empty", 64'(expQ.size()), 64'd0);

      // Reset pulse mid-frame, then a fresh frame
      rise(40'h9C_5A3E_71D2);
      repeat (19) @(posedge sClk);
      #3;
      reset_n = 1'b0;
      expQ.delete();
      #1;
      check("t6OutReady", {63'd0, bus.outReady}, 64'd0);
      check("t6OutBit",   {63'd0, bus.outBit},   64'd0);
      check("t6Busy",     {63'd0, bus.busy},     64'd0);
      check("t6Overflow", {63'd0, bus.overflow}, 64'd0);
      @(posedge sClk);
      #2;
      reset_n = 1'b1;
      rise(40'hB7_6E5D_4C3B);
      measureRun(len);
      check("t6Len", 64'(len), 64'd40);
      check("t6Empty", 64'(expQ.size()), 64'd0);

      monOn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/output_serializer.md
# output_serializer

Downstream stage of the per-sample calculation block. Captures each 40-bit filter result when the calculator signals completion, then shifts it out MSB-first, one bit per `sClk` cycle, with a frame-valid strobe. A one-entry pending register absorbs a result that arrives while a previous one is still shifting; a sticky flag reports any result lost beyond that.

## Interface
- `RESULT_WIDTH`, default 40: width of the result word and serial frame length in bits.
- `sClk`: input, 1 bit. System clock; all state updates on the rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `overallResult`: input, `RESULT_WIDTH` bits. Result word from the calculator; valid whenever `thisNCompleted` is high.
- `thisNCompleted`: input, 1 bit. Level from the calculator; a low-to-high transition marks a new result.
- `outBit`: output, 1 bit. Serial data, MSB first.
- `outReady`: output, 1 bit. High on every cycle in which `outBit` carries a frame bit.
- `busy`: output, 1 bit. High in SHIFT state or whenever `pendingValid` is set.
- `overflow`: output, 1 bit. Sticky; set when a result is dropped.

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `shiftReg`, `pendingReg`, `pendingValid`, `bitCount` all 0.
  - `doneD` = 0.
- Edge detect: `newResult = thisNCompleted & ~doneD`. `doneD` is `thisNCompleted` registered every cycle. A level held high produces exactly one `newResult`.
- IDLE, on `newResult`:
  - Load `overallResult` into the shifter: `outBit <= overallResult[MSB]`, `shiftReg <= overallResult << 1`.
  - `outReady <= 1`, `bitCount <= 0`, go to SHIFT.
- SHIFT, each cycle:
  - `outBit <= shiftReg[MSB]`, `shiftReg <= shiftReg << 1`, `bitCount++`.
  - When `bitCount == RESULT_WIDTH-1` (last bit on the outputs this cycle), the next edge does one of:
    - Reload from `pendingReg` if `pendingValid`, then clear `pendingValid`.
    - Otherwise reload from `overallResult` if `newResult` is asserted this cycle.
    - Otherwise go to IDLE with `outReady <= 0` and `outBit <= 0`.
- `newResult` while in SHIFT and not on the last bit:
  - If `pendingValid` = 0: `pendingReg <= overallResult`, `pendingValid <= 1`.
  - If `pendingValid` = 1: drop the new result and set `overflow <= 1`. The pending word is kept.
- `newResult` on the last-bit cycle with `pendingValid` = 1: pending goes to the shifter, the new word goes to `pendingReg` with `pendingValid` staying 1. No overflow.
- `overflow` clears only on reset.
- Reset mid-frame: the frame is aborted immediately, with no partial completion.

## Timing
- Latency: `newResult` sampled at edge E makes `outReady` = 1 and `outBit` = bit 39 visible after E. Bit 0 is visible after edge E+39.
- A frame is exactly `RESULT_WIDTH` consecutive cycles of `outReady` = 1.
- Back-to-back frames have zero gap: `outReady` stays high and bit 39 of the next word immediately follows bit 0 of the previous one.
- When `outReady` = 0, `outBit` is 0.
- Throughput: one result per `RESULT_WIDTH` cycles sustained. Burst tolerance is 2 results: one in the shifter, one pending.

## Structure
- Shared package holds:
  - `RESULT_WIDTH` (40), shared with the calculator's result bus.
  - The state encoding: IDLE = 1'b0, SHIFT = 1'b1.
  - The counter width, `$clog2(RESULT_WIDTH)` = 6.
- Single module; no sub-module. The edge detector is inline.

## Test plan
- Reset, then one `thisNCompleted` rise with `overallResult` = 40'h80_0000_0001:
  - `outReady` high for 40 cycles.
  - `outBit` = 1 in cycle 1, 0 in cycles 2–39, 1 in cycle 40.
  - Then IDLE, with all outputs returning to 0.
- `thisNCompleted` held high for 200 cycles with value 40'hFF_FFFF_FFFF: exactly one 40-bit frame of ones, then idle. `overflow` stays 0.
- Second rise (40'hAA_AAAA_AAAA) at frame bit 10 of a frame carrying 40'h12_3456_789A:
  - First word is sent completely.
  - 40'hAAAAAAAAAA follows with no gap (80 continuous `outReady` cycles).
  - `busy` falls after cycle 80.
- Three rises inside one frame (words A, B, C): A and B are output back-to-back, C is never output, and `overflow` goes to 1 and stays set.
- A rise coinciding with the last-bit cycle while `pendingValid` = 1: the pending word is output next and the new word is output after it. `overflow` stays 0.
- `reset_n` pulsed low at frame bit 20: `outReady`, `outBit`, `busy` and `overflow` go to 0 asynchronously. After release, a fresh rise produces a full, correct 40-bit frame.
